frame_load_ctrl: RTL and testbench

- Sequences a parsed image stream (header dims, then RGB pixels) into a double-buffered frame memory.
- Sits between the parser (height/width/RGB/data_ready) and frame-buffer RAM.
- Generates write enable, address and data into the back bank.
- Swaps banks atomically on frame completion so the display side always reads a complete frame.
- Detects zero-size headers, truncated frames and stalled streams.

---
 rtl/frame_load_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_frame_load_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_load_ctrl.sv
// Purpose : sequences parsed image headers/pixels into the back bank of a double-buffered frame RAM.
// Latency : one cycle from an accepted pixel to its RAM write; bank swap on the edge that ends DONE.
// Backpressure: none -- the parser cannot be stalled; pixels outside LOAD are dropped, a header seen in DONE is held.
//
// Ports:
//   clk, reset (async, active-low)
//   hdr_valid/height/width       : frame header from parser, starts a frame
//   pix_valid/pix_r/pix_g/pix_b  : one pixel per pulse
//   wr_en/wr_addr/wr_data        : frame-RAM write port, wr_addr = {bank, pixel index}
//   disp_bank/disp_height/width  : bank and dimensions of the last complete frame
//   frame_done, busy, err        : swap pulse, LOAD/DONE indicator, sticky error
module frame_load_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hdr_valid,
    input  logic [7:0]        height,
    input  logic [7:0]        width,
    input  logic              pix_valid,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [23:0]       wr_data,
    output logic              disp_bank,
    output logic [7:0]        disp_height,
    output logic [7:0]        disp_width,
    output logic              frame_done,
    output logic              busy,
    output logic              err
);

    localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          h_q, h_d, w_q, w_d;
    logic [7:0]          row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                disp_bank_q, disp_bank_d;
    logic [7:0]          disp_h_q, disp_h_d, disp_w_q, disp_w_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
    logic [23:0]         wr_data_q, wr_data_d;
    // Header captured during DONE, replayed in the following IDLE cycle.
    logic                pend_vld_q, pend_vld_d;
    logic [7:0]          pend_h_q, pend_h_d, pend_w_q, pend_w_d;

    // Header seen by IDLE: a fresh pulse supersedes one held over from DONE.
    logic                idle_hdr;
    logic [7:0]          idle_h, idle_w;

    always_comb begin
        idle_hdr = hdr_valid | pend_vld_q;
        idle_h   = hdr_valid ? height : pend_h_q;
        idle_w   = hdr_valid ? width  : pend_w_q;
    end

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        w_d         = w_q;
        row_d       = row_q;
        col_d       = col_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        disp_bank_d = disp_bank_q;
        disp_h_d    = disp_h_q;
        disp_w_d    = disp_w_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        pend_vld_d  = pend_vld_q;
        pend_h_d    = pend_h_q;
        pend_w_d    = pend_w_q;

        case (state_q)
            S_IDLE: begin
                pend_vld_d = 1'b0;
                if (idle_hdr) begin
                    if (idle_h != 8'd0 && idle_w != 8'd0) begin
                        h_d     = idle_h;
                        w_d     = idle_w;
                        row_d   = 8'd0;
                        col_d   = 8'd0;
                        idx_d   = '0;
                        tmo_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (hdr_valid) begin
                    // Truncated frame: flag it, then treat the header as in IDLE
                    // except that err stays set until a later clean header.
                    err_d = 1'b1;
                    if (height != 8'd0 && width != 8'd0) begin
                        h_d   = height;
                        w_d   = width;
                        row_d = 8'd0;
                        col_d = 8'd0;
                        idx_d = '0;
                        tmo_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (pix_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {~disp_bank_q, idx_q};
                    wr_data_d = {pix_r, pix_g, pix_b};
                    idx_d     = idx_q + ADDR_W'(1);
                    tmo_d     = '0;
                    if (col_q == w_q - 8'd1) begin
                        col_d = 8'd0;
                        if (row_q == h_q - 8'd1) begin
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 8'd1;
                        end
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_DONE: begin
                disp_bank_d = ~disp_bank_q;
                disp_h_d    = h_q;
                disp_w_d    = w_q;
                state_d     = S_IDLE;
                if (hdr_valid) begin
                    pend_vld_d = 1'b1;
                    pend_h_d   = height;
                    pend_w_d   = width;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            h_q         <= 8'd0;
            w_q         <= 8'd0;
            row_q       <= 8'd0;
            col_q       <= 8'd0;
            idx_q       <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            disp_bank_q <= 1'b0;
            disp_h_q    <= 8'd0;
            disp_w_q    <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 24'd0;
            pend_vld_q  <= 1'b0;
            pend_h_q    <= 8'd0;
            pend_w_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            w_q         <= w_d;
            row_q       <= row_d;
            col_q       <= col_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            disp_bank_q <= disp_bank_d;
            disp_h_q    <= disp_h_d;
            disp_w_q    <= disp_w_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pend_vld_q  <= pend_vld_d;
            pend_h_q    <= pend_h_d;
            pend_w_q    <= pend_w_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign disp_bank   = disp_bank_q;
    assign disp_height = disp_h_q;
    assign disp_width  = disp_w_q;
    assign err         = err_q;
    assign frame_done  = (state_q == S_DONE);
    assign busy        = (state_q == S_LOAD) || (state_q == S_DONE);

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Bench for frame_load_ctrl: directed scenarios plus randomized frames, each
// checked against expected write streams built from frame dimensions and a
// model of which bank is currently displayed.
module tb_frame_load_ctrl;

    localparam int ADDR_W = 16;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              hdr_valid = 1'b0;
    logic [7:0]        height = 8'd0;
    logic [7:0]        width = 8'd0;
    logic              pix_valid = 1'b0;
    logic [7:0]        pix_r = 8'd0;
    logic [7:0]        pix_g = 8'd0;
    logic [7:0]        pix_b = 8'd0;
    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic [23:0]       wr_data;
    logic              disp_bank;
    logic [7:0]        disp_height;
    logic [7:0]        disp_width;
    logic              frame_done;
    logic              busy;
    logic              err;

    frame_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset),
        .hdr_valid(hdr_valid), .height(height), .width(width),
        .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .disp_bank(disp_bank), .disp_height(disp_height), .disp_width(disp_width),
        .frame_done(frame_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W:0] addr;
        logic [23:0]     data;
        int              c;
    } wr_t;

    wr_t mon_q[$];
    wr_t exp_q[$];
    int  fd_q[$];
    wr_t mon_e;

    // Observe the RAM port and swap pulse away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (wr_en === 1'b1) begin
                mon_e.addr = wr_addr;
                mon_e.data = wr_data;
                mon_e.c    = cyc;
                mon_q.push_back(mon_e);
            end
            if (frame_done === 1'b1) fd_q.push_back(cyc);
        end
    end

    int   n_chk = 0;
    int   n_fail = 0;
    logic exp_disp = 1'b0;

    // ---------------- stimulus / model helpers ----------------
    task automatic clear_q();
        mon_q.delete(); exp_q.delete(); fd_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0; hdr_valid = 1'b0; pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_q();
        exp_disp = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] h, input logic [7:0] w);
        hdr_valid = 1'b1; height = h; width = w;
        @(negedge clk);
        hdr_valid = 1'b0;
    endtask

    task automatic send_pix(input logic [23:0] rgb, output int c);
        pix_valid = 1'b1; {pix_r, pix_g, pix_b} = rgb;
        c = cyc;
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    // Pixel k of a frame lands at index k of the non-displayed bank one cycle later.
    task automatic push_exp(input int idx, input logic [23:0] rgb, input int c);
        wr_t e;
        e.addr = {~exp_disp, ADDR_W'(idx)};
        e.data = rgb;
        e.c    = c + 1;
        exp_q.push_back(e);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        wait_cyc(2);
        n_chk++;
        if ({wr_en, wr_addr, wr_data} !== '0) begin
            n_fail++; $display("FAIL reset_wr: got en=%b addr=%h data=%h, expected all 0", wr_en, wr_addr, wr_data);
        end
        n_chk++;
        if ({disp_bank, disp_height, disp_width} !== 17'd0) begin
            n_fail++; $display("FAIL reset_disp: got bank=%b h=%0d w=%0d, expected 0", disp_bank, disp_height, disp_width);
        end
        n_chk++;
        if ({frame_done, busy, err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status: got fd/busy/err=%b, expected 000", {frame_done, busy, err});
        end
        reset = 1'b1;
        wait_cyc(1);
        clear_q();
        exp_disp = 1'b0;
    endtask

    task automatic test_basic();
        int c, last;
        logic [23:0] rgb;
        clear_q();
        send_hdr(8'd2, 8'd3);
        n_chk++;
        if ({busy, err} !== 2'b10) begin
            n_fail++; $display("FAIL basic_start: got busy/err=%b, expected 10", {busy, err});
        end
        for (int k = 1; k <= 6; k++) begin
            rgb = {8'(k), 8'(k + 1), 8'(k + 2)};
            send_pix(rgb, c);
            push_exp(k - 1, rgb, c);
            last = c;
        end
        wait_cyc(3);
        exp_disp = ~exp_disp;
        n_chk++;
        if (mon_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL basic_wr_count: got %0d, expected %0d", mon_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < mon_q.size()) begin
            n_chk++;
            if (mon_q[i].addr !== exp_q[i].addr || mon_q[i].data !== exp_q[i].data || mon_q[i].c !== exp_q[i].c) begin
                n_fail++; $display("FAIL basic_wr[%0d]: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                                   i, mon_q[i].addr, mon_q[i].data, mon_q[i].c, exp_q[i].addr, exp_q[i].data, exp_q[i].c);
            end
        end
        n_chk++;
        if (fd_q.size() !== 1 || (fd_q.size() > 0 && fd_q[0] !== last + 1)) begin
            n_fail++; $display("FAIL basic_frame_done: got %0d pulses, expected 1 at cyc %0d", fd_q.size(), last + 1);
        end
        n_chk++;
        if ({disp_bank, disp_height, disp_width, err, busy} !== {1'b1, 8'd2, 8'd3, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL basic_disp: got bank=%b h=%0d w=%0d err=%b busy=%b, expected 1 2 3 0 0",
                               disp_bank, disp_height, disp_width, err, busy);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            send_hdr(8'd1, 8'd1);
            send_pix(24'hA0B0C0 + 24'(f), c);
            push_exp(0, 24'hA0B0C0 + 24'(f), c);
            wait_cyc(2);
            exp_disp = ~exp_disp;
            n_chk++;
            if (disp_bank !== exp_disp) begin
                n_fail++; $display("FAIL b2b_bank[%0d]: got %b, expected %b", f, disp_bank, exp_disp);
            end
        end
        n_chk++;
        if (mon_q.size() !== 2) begin
            n_fail++; $display("FAIL b2b_wr_count: got %0d, expected 2", mon_q.size());
        end
        foreach (exp_q[i]) if (i < mon_q.size()) begin
            n_chk++;
            if (mon_q[i].addr !== exp_q[i].addr || mon_q[i].data !== exp_q[i].data) begin
                n_fail++; $display("FAIL b2b_wr[%0d]: got addr=%h data=%h, expected addr=%h data=%h",
                                   i, mon_q[i].addr, mon_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_chk++;
        if (fd_q.size() !== 2) begin
            n_fail++; $display("FAIL b2b_frame_done: got %0d pulses, expected 2", fd_q.size());
        end
    endtask

    task automatic test_zero_hdr();
        int c;
        clear_q();
        send_hdr(8'd0, 8'd5);
        n_chk++;
        if ({err, busy} !== 2'b10) begin
            n_fail++; $display("FAIL zero_h: got err/busy=%b, expected 10", {err, busy});
        end
        send_hdr(8'd4, 8'd0);
        send_pix(24'h123456, c);   // IDLE: must be dropped
        wait_cyc(2);
        n_chk++;
        if ({err, busy} !== 2'b10 || mon_q.size() !== 0) begin
            n_fail++; $display("FAIL zero_w: got err/busy=%b writes=%0d, expected 10 and 0", {err, busy}, mon_q.size());
        end
        send_hdr(8'd1, 8'd1);
        n_chk++;
        if ({err, busy} !== 2'b01) begin
            n_fail++; $display("FAIL zero_recover: got err/busy=%b, expected 01", {err, busy});
        end
        send_pix(24'h0F1E2D, c);
        push_exp(0, 24'h0F1E2D, c);
        wait_cyc(2);
        exp_disp = ~exp_disp;
        n_chk++;
        if (mon_q.size() !== 1 || (mon_q.size() > 0 && (mon_q[0].addr !== exp_q[0].addr || mon_q[0].data !== exp_q[0].data))) begin
            n_fail++; $display("FAIL zero_wr: got %0d writes, expected 1 at addr %h", mon_q.size(), exp_q[0].addr);
        end
        n_chk++;
        if (fd_q.size() !== 1 || disp_bank !== exp_disp || err !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: got fd=%0d bank=%b err=%b, expected 1 %b 0", fd_q.size(), disp_bank, exp_disp, err);
        end
    endtask

    task automatic test_timeout();
        int c;
        clear_q();
        send_hdr(8'd2, 8'd2);
        for (int k = 0; k < 2; k++) begin
            send_pix(24'(32'h00550000 + k), c);
            push_exp(k, 24'(32'h00550000 + k), c);
        end
        wait_cyc(TMO - 1);
        n_chk++;
        if ({busy, err} !== 2'b10) begin
            n_fail++; $display("FAIL tmo_before: got busy/err=%b after %0d idle cycles, expected 10", {busy, err}, TMO - 1);
        end
        wait_cyc(1);
        n_chk++;
        if ({busy, err} !== 2'b01) begin
            n_fail++; $display("FAIL tmo_expire: got busy/err=%b after %0d idle cycles, expected 01", {busy, err}, TMO);
        end
        send_pix(24'hFFFFFF, c);   // back in IDLE: dropped
        wait_cyc(2);
        n_chk++;
        if (disp_bank !== exp_disp || fd_q.size() !== 0 || mon_q.size() !== 2 || {disp_height, disp_width} !== {8'd1, 8'd1}) begin
            n_fail++; $display("FAIL tmo_state: got bank=%b fd=%0d writes=%0d h=%0d w=%0d, expected %b 0 2 1 1",
                               disp_bank, fd_q.size(), mon_q.size(), disp_height, disp_width, exp_disp);
        end
    endtask

    task automatic test_collision();
        int c;
        clear_q();
        send_hdr(8'd2, 8'd2);
        send_pix(24'h111111, c);
        push_exp(0, 24'h111111, c);
        hdr_valid = 1'b1; height = 8'd1; width = 8'd1;
        pix_valid = 1'b1; {pix_r, pix_g, pix_b} = 24'h222222;
        @(negedge clk);
        hdr_valid = 1'b0; pix_valid = 1'b0;
        n_chk++;
        if ({err, busy} !== 2'b11) begin
            n_fail++; $display("FAIL coll_err: got err/busy=%b, expected 11", {err, busy});
        end
        send_pix(24'h333333, c);
        push_exp(0, 24'h333333, c);
        wait_cyc(2);
        exp_disp = ~exp_disp;
        n_chk++;
        if (mon_q.size() !== 2) begin
            n_fail++; $display("FAIL coll_wr_count: got %0d, expected 2", mon_q.size());
        end
        foreach (exp_q[i]) if (i < mon_q.size()) begin
            n_chk++;
            if (mon_q[i].addr !== exp_q[i].addr || mon_q[i].data !== exp_q[i].data || mon_q[i].c !== exp_q[i].c) begin
                n_fail++; $display("FAIL coll_wr[%0d]: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                                   i, mon_q[i].addr, mon_q[i].data, mon_q[i].c, exp_q[i].addr, exp_q[i].data, exp_q[i].c);
            end
        end
        n_chk++;
        if (fd_q.size() !== 1 || err !== 1'b1 || disp_bank !== exp_disp || {disp_height, disp_width} !== {8'd1, 8'd1}) begin
            n_fail++; $display("FAIL coll_done: got fd=%0d err=%b bank=%b h=%0d w=%0d, expected 1 1 %b 1 1",
                               fd_q.size(), err, disp_bank, disp_height, disp_width, exp_disp);
        end
        send_hdr(8'd1, 8'd1);
        n_chk++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL coll_err_clear: got err=%b, expected 0", err);
        end
        send_pix(24'h444444, c);
        wait_cyc(2);
        exp_disp = ~exp_disp;
    endtask

    task automatic test_hdr_in_done();
        int c;
        clear_q();
        send_hdr(8'd1, 8'd2);
        send_pix(24'hAA0001, c); push_exp(0, 24'hAA0001, c);
        send_pix(24'hAA0002, c); push_exp(1, 24'hAA0002, c);
        send_hdr(8'd1, 8'd1);      // lands in the DONE cycle
        exp_disp = ~exp_disp;
        wait_cyc(1);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL done_hdr_held: got busy=%b, expected 1", busy);
        end
        send_pix(24'hBB0001, c); push_exp(0, 24'hBB0001, c);
        wait_cyc(2);
        exp_disp = ~exp_disp;
        n_chk++;
        if (mon_q.size() !== 3) begin
            n_fail++; $display("FAIL done_wr_count: got %0d, expected 3", mon_q.size());
        end
        foreach (exp_q[i]) if (i < mon_q.size()) begin
            n_chk++;
            if (mon_q[i].addr !== exp_q[i].addr || mon_q[i].data !== exp_q[i].data) begin
                n_fail++; $display("FAIL done_wr[%0d]: got addr=%h data=%h, expected addr=%h data=%h",
                                   i, mon_q[i].addr, mon_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_chk++;
        if (fd_q.size() !== 2 || disp_bank !== exp_disp) begin
            n_fail++; $display("FAIL done_swap: got fd=%0d bank=%b, expected 2 %b", fd_q.size(), disp_bank, exp_disp);
        end
    endtask

    task automatic test_reset_mid_load();
        int c;
        do_reset();
        send_hdr(8'd1, 8'd1);
        send_pix(24'h010101, c);
        wait_cyc(2);
        send_hdr(8'd4, 8'd4);
        for (int k = 0; k < 3; k++) send_pix(24'h777700 + 24'(k), c);
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({wr_en, wr_addr, wr_data, disp_bank, disp_height, disp_width, frame_done, busy, err} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: got en=%b addr=%h data=%h bank=%b h=%0d w=%0d fd=%b busy=%b err=%b, expected all 0",
                               wr_en, wr_addr, wr_data, disp_bank, disp_height, disp_width, frame_done, busy, err);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_q();
        exp_disp = 1'b0;
        send_hdr(8'd1, 8'd1);
        send_pix(24'h5A5A5A, c);
        push_exp(0, 24'h5A5A5A, c);
        wait_cyc(2);
        exp_disp = ~exp_disp;
        n_chk++;
        if (mon_q.size() !== 1 || (mon_q.size() > 0 && mon_q[0].addr !== exp_q[0].addr)) begin
            n_fail++; $display("FAIL midreset_next: got %0d writes, expected 1 at addr %h", mon_q.size(), exp_q[0].addr);
        end
        n_chk++;
        if (disp_bank !== exp_disp) begin
            n_fail++; $display("FAIL midreset_bank: got %b, expected %b", disp_bank, exp_disp);
        end
    endtask

    task automatic test_random_frames();
        int c, last, h, w;
        logic [23:0] rgb;
        for (int f = 0; f < 10; f++) begin
            clear_q();
            if (f == 0) begin h = 1; w = 255; end
            else if (f == 1) begin h = 255; w = 1; end
            else begin h = $urandom_range(1, 6); w = $urandom_range(1, 6); end
            send_hdr(8'(h), 8'(w));
            for (int k = 0; k < h * w; k++) begin
                if (f > 1) wait_cyc($urandom_range(0, 3));
                rgb = 24'($urandom);
                send_pix(rgb, c);
                push_exp(k, rgb, c);
                last = c;
            end
            wait_cyc(2);
            exp_disp = ~exp_disp;
            n_chk++;
            if (mon_q.size() !== exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_wr_count (%0dx%0d): got %0d, expected %0d", f, h, w, mon_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < mon_q.size()) begin
                n_chk++;
                if (mon_q[i].addr !== exp_q[i].addr || mon_q[i].data !== exp_q[i].data || mon_q[i].c !== exp_q[i].c) begin
                    n_fail++; $display("FAIL rand%0d_wr[%0d]: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                                       f, i, mon_q[i].addr, mon_q[i].data, mon_q[i].c, exp_q[i].addr, exp_q[i].data, exp_q[i].c);
                end
            end
            n_chk++;
            if (fd_q.size() !== 1 || (fd_q.size() > 0 && fd_q[0] !== last + 1)) begin
                n_fail++; $display("FAIL rand%0d_frame_done: got %0d pulses, expected 1 at cyc %0d", f, fd_q.size(), last + 1);
            end
            n_chk++;
            if ({disp_bank, disp_height, disp_width, err} !== {exp_disp, 8'(h), 8'(w), 1'b0}) begin
                n_fail++; $display("FAIL rand%0d_disp: got bank=%b h=%0d w=%0d err=%b, expected %b %0d %0d 0",
                                   f, disp_bank, disp_height, disp_width, err, exp_disp, h, w);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_hdr();
        test_timeout();
        test_collision();
        test_hdr_in_done();
        test_reset_mid_load();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
